// File: rtl/aes_sub_bytes_serial.sv
// Multi-cycle AES SubBytes/InvSubBytes engine: a 128-bit state is substituted
// NUM_SBOX bytes per cycle through a small bank of shared S-box lookups.

module aes_sbox_lut (
  input  logic       i_inv,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [7:0] INV_EXP = 8'hFE;  // a^254 == a^-1 in GF(2^8)

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (INV_EXP[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  logic [7:0] w_pre;
  logic [7:0] w_ginv;

  // Forward: inverse then affine. Inverse: inverse-affine then inverse.
  // Both directions share one field inverter.
  always_comb begin
    w_pre  = i_inv ? (rotl(i_byte, 1) ^ rotl(i_byte, 3) ^ rotl(i_byte, 6) ^ 8'h05) : i_byte;
    w_ginv = gf_inv(w_pre);
    o_byte = i_inv ? w_ginv
                   : (w_ginv ^ rotl(w_ginv, 1) ^ rotl(w_ginv, 2) ^ rotl(w_ginv, 3) ^ rotl(w_ginv, 4) ^ 8'h63);
  end
endmodule

module aes_sub_bytes_serial #(
  parameter int NUM_SBOX = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);
  localparam int G     = 16 / NUM_SBOX;
  localparam int CNT_W = (G > 1) ? $clog2(G) : 1;

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
      $error("aes_sub_bytes_serial: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [127:0]               r_data;
  logic                       r_op;
  logic [CNT_W-1:0]           r_cnt;
  logic                       w_last;
  logic                       w_accept;
  logic [NUM_SBOX-1:0][7:0]   w_lut_in;
  logic [NUM_SBOX-1:0][7:0]   w_lut_out;
  logic [127:0]               w_data_sub;

  assign w_last   = (r_cnt == CNT_W'(G - 1));
  assign w_accept = (r_state == S_IDLE) && in_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (out_ready_i) w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are masked by reset combinationally.
  always_comb begin
    in_ready_o  = (r_state == S_IDLE) && !rst_i;
    out_valid_o = (r_state == S_DONE) && !rst_i;
    busy_o      = (r_state != S_IDLE);
    data_o      = r_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_op   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_data <= data_i;
      r_op   <= op_i;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_data <= w_data_sub;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Byte k belongs to group k/NUM_SBOX and lane k%NUM_SBOX.
  always_comb begin
    w_lut_in = '0;
    for (int k = 0; k < 16; k++)
      if (r_cnt == CNT_W'(k / NUM_SBOX)) w_lut_in[k % NUM_SBOX] = r_data[8*k +: 8];
  end

  always_comb begin
    w_data_sub = r_data;
    for (int k = 0; k < 16; k++)
      if (r_cnt == CNT_W'(k / NUM_SBOX)) w_data_sub[8*k +: 8] = w_lut_out[k % NUM_SBOX];
  end

  generate
    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
      aes_sbox_lut u_lut (
        .i_inv  (r_op),
        .i_byte (w_lut_in[j]),
        .o_byte (w_lut_out[j])
      );
    end
  endgenerate
endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// Scoreboard bench: three engines (NUM_SBOX 1/4/16) checked against a
// table-driven S-box model derived from GF(2^8) arithmetic.

module tb_aes_sub_bytes_serial;
  localparam logic [127:0] ASC   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] ASC_F = 128'h76ABD7FE2B670130C56F6BF27B777C63;
  localparam logic [127:0] ZER_F = 128'h63636363636363636363636363636363;

  logic         clk, rst;
  logic         op        [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] din       [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] dout      [3];
  logic         busy      [3];

  aes_sub_bytes_serial #(.NUM_SBOX(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .op_i(op[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .data_i(din[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .data_o(dout[0]), .busy_o(busy[0]));
  aes_sub_bytes_serial #(.NUM_SBOX(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .op_i(op[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .data_i(din[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .data_o(dout[1]), .busy_o(busy[1]));
  aes_sub_bytes_serial #(.NUM_SBOX(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .op_i(op[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .data_i(din[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .data_o(dout[2]), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q [3][$];
  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];

  function automatic int g_of(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : 1;
  endfunction

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int bt = 14; bt >= 8; bt--) if (p[bt]) p = p ^ (16'h011B << (bt - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] c, v, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = v[b] ^ v[(b+4)%8] ^ v[(b+5)%8] ^ v[(b+6)%8] ^ v[(b+7)%8] ^ c[b];
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic o);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = o ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Waits for in_ready, issues one state, pushes the expectation, then
  // scrambles inputs and measures cycles until out_valid.
  task automatic send(input int i, input logic [127:0] d, input logic o,
                      input logic [127:0] e, output int acc);
    int  n;
    bit  ok;
    ok = 0;
    acc = -1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready[i]) begin ok = 1; break; end
    end
    if (!ok) begin
      chk($sformatf("in_ready_timeout%0d", i), 128'(in_ready[i]), 128'd1);
      return;
    end
    in_valid[i] = 1'b1; din[i] = d; op[i] = o;
    exp_q[i].push_back(e);
    acc = cyc;
    @(posedge clk); #1;
    in_valid[i] = 1'b0; din[i] = {$urandom, $urandom, $urandom, $urandom}; op[i] = ~o;
    ok = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (out_valid[i]) begin ok = 1; break; end
    end
    chk($sformatf("latency%0d", i), 128'(n), 128'(g_of(i) + 1));
  endtask

  int           acc, prev;
  logic [127:0] hold, d;
  logic         o;
  bit           seen;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op[i] = 1'b0; in_valid[i] = 1'b0; din[i] = '0; out_ready[i] = 1'b1;
    end
    build_tables();
    fork
      forever begin
        @(negedge clk);
        if (!rst)
          for (int i = 0; i < 3; i++)
            if (out_valid[i] && out_ready[i]) begin
              if (exp_q[i].size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out%0d got=%h exp=<none>", i, dout[i]);
              end else begin
                chk($sformatf("data%0d", i), dout[i], exp_q[i][0]);
                void'(exp_q[i].pop_front());
              end
            end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 128'(in_ready[i]), 128'd1);
      chk($sformatf("rst_out_valid%0d", i), 128'(out_valid[i]), 128'd0);
      chk($sformatf("rst_busy%0d", i), 128'(busy[i]), 128'd0);
      chk($sformatf("rst_data%0d", i), dout[i], 128'h0);
    end

    // Directed vectors
    send(0, 128'h0, 1'b0, ZER_F, acc);
    for (int i = 0; i < 3; i++) send(i, ASC, 1'b0, ASC_F, acc);
    send(0, ASC_F, 1'b1, ASC, acc);
    send(2, ASC_F, 1'b1, ASC, acc);
    send(0, 128'hED, 1'b1, model(128'hED, 1'b1), acc);

    // Back-to-back period with out_ready tied high
    for (int i = 0; i < 3; i++) begin
      prev = -1;
      for (int r = 0; r < 4; r++) begin
        d = {$urandom, $urandom, $urandom, $urandom}; o = 1'($urandom_range(0, 1));
        send(i, d, o, model(d, o), acc);
        if (r > 0) chk($sformatf("period%0d", i), 128'(acc - prev), 128'(g_of(i) + 2));
        prev = acc;
      end
    end

    // Backpressure in DONE
    @(posedge clk); #1 out_ready[0] = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(0, d, 1'b0, model(d, 1'b0), acc);
    hold = dout[0];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 in_valid[0] = 1'b1; din[0] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_data_hold", dout[0], hold);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    @(posedge clk); #1 in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
    chk("bp_release_busy", 128'(busy[0]), 128'd0);

    // Reset during RUN discards the operation
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = in_ready[0];
    end
    in_valid[0] = 1'b1; din[0] = {$urandom, $urandom, $urandom, $urandom}; op[0] = 1'b0;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstrun_in_ready_gated", 128'(in_ready[1]), 128'd0);
    chk("rstrun_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rstrun_busy_before", 128'(busy[0]), 128'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstrun_busy", 128'(busy[0]), 128'd0);
    chk("rstrun_in_ready", 128'(in_ready[0]), 128'd1);
    chk("rstrun_data", dout[0], 128'h0);
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1;
    end
    chk("rstrun_no_output", 128'(seen), 128'd0);

    // Randomised traffic with idle gaps and occasional stalls
    for (int t = 0; t < 24; t++) begin
      int i, gap, stall;
      i = $urandom_range(0, 2);
      gap = $urandom_range(0, 3);
      stall = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      @(posedge clk); #1 out_ready[i] = (stall != 0);
      d = {$urandom, $urandom, $urandom, $urandom}; o = 1'($urandom_range(0, 1));
      send(i, d, o, model(d, o), acc);
      if (stall == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 out_ready[i] = 1'b1;
      end
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 128'(exp_q[i].size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_sub_bytes_serial.md
# aes_sub_bytes_serial

Multi-cycle SubBytes / InvSubBytes engine for the AES cipher core. It accepts a 128-bit state over a valid/ready handshake and substitutes its 16 bytes through a small bank of internal `aes_sbox_lut`-equivalent lookups. It returns the substituted state over a second valid/ready handshake. It is the initiator side of the S-box lookup interface, time-multiplexing `NUM_SBOX` lookup instances to trade latency for area.

## Interface
- `NUM_SBOX`, default 1: number of parallel S-box lookups per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- `clk_i`  input  1  clock; all state updates on its rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `op_i`  input  1  cipher direction: 0 = CIPH_FWD (SubBytes), 1 = CIPH_INV (InvSubBytes); sampled only on input handshake.
- `in_valid_i`  input  1  input state valid.
- `in_ready_o`  output  1  block can accept a state.
- `data_i`  input  128  input state; byte k = `data_i[8k+:8]`.
- `out_valid_o`  output  1  substituted state available.
- `out_ready_i`  input  1  downstream accepts output.
- `data_o`  output  128  substituted state; byte k = `data_o[8k+:8]`.
- `busy_o`  output  1  high in RUN or DONE.

## Operation
- G = 16 / NUM_SBOX lookup groups. Internal registers:
  - 128-bit working register `state_q`.
  - latched direction `op_q`.
  - group counter `cnt_q`, log2(G) bits, minimum 1 bit.
  - FSM state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready_o` = 1.
  - On `in_valid_i && in_ready_o`: `state_q <= data_i`, `op_q <= op_i`, `cnt_q <= 0`, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle, bytes k = cnt_q·NUM_SBOX … cnt_q·NUM_SBOX+NUM_SBOX−1 of `state_q` are replaced by SBOX(op_q, byte).
  - `cnt_q` increments each cycle.
  - When `cnt_q == G−1`, the last group is written and the FSM goes to DONE. `cnt_q` wraps to 0.
  - Bytes are processed in ascending index order. Already-substituted bytes are never substituted again.
- DONE:
  - `out_valid_o` = 1.
  - `state_q` is held. `data_o` is stable until handshake.
  - On `out_ready_i`: go to IDLE.
- `data_o` = `state_q` at all times. Its value is meaningful only while `out_valid_o` = 1.
- `busy_o` = (state != IDLE).
- Handshake rules:
  - `in_valid_i` outside IDLE is ignored; no input is buffered.
  - `op_i` and `data_i` changes after acceptance have no effect.
  - `out_valid_o` is never withdrawn before `out_ready_i`.
  - No input is accepted in the same cycle as the output handshake.
- S-box contents are the standard FIPS-197 forward and inverse tables, combinationally indexed by byte value.
- Reset:
  - While `rst_i` = 1, `in_ready_o` = 0 and `out_valid_o` = 0. Both are gated combinationally.
  - Next state after any cycle with `rst_i` = 1: IDLE, `cnt_q` = 0, `state_q` = 0, `op_q` = 0.
  - Reset in RUN or DONE discards the operation. No output is produced for it.

## Timing
- Reset values, first cycle after reset deasserts:
  - `in_ready_o` = 1.
  - `out_valid_o` = 0.
  - `busy_o` = 0.
  - `data_o` = 128'h0.
- Input handshake at edge 0: RUN during cycles 1…G, and `out_valid_o` = 1 from cycle G+1.
  - NUM_SBOX=1: 17 cycles.
  - NUM_SBOX=4: 5 cycles.
  - NUM_SBOX=16: 2 cycles.
- Output handshake at cycle D: IDLE in cycle D+1, `in_ready_o` = 1 in D+1.
- Minimum input-to-input period with `out_ready_i` tied high: G+2 cycles.
- All outputs are functions of registered state, except the `rst_i` gating of `in_ready_o` and `out_valid_o`. There is no combinational path from `data_i` or `op_i` to any output.

## Test plan
- **Zero state forward.** NUM_SBOX=1, `op_i`=0, `data_i`=0 → `out_valid_o` rises exactly 17 cycles after acceptance, with `data_o` = all bytes 0x63 (128'h63636363636363636363636363636363).
- **Ascending bytes forward.** `data_i`=128'h0F0E0D0C0B0A09080706050403020100, `op_i`=0 → `data_o`=128'h76ABD7FE2B670130C56F6BF27B777C63.
- **Round trip.** Feed that result back with `op_i`=1 → `data_o`=128'h0F0E0D0C0B0A09080706050403020100. Also `data_i` byte 0=0xED, `op_i`=1 → byte 0 = 0x53.
- **Backpressure.** Hold `out_ready_i`=0 for 5 cycles in DONE → `out_valid_o` stays 1, `data_o` stays constant, `in_ready_o`=0, and `in_valid_i` pulses are ignored. Release → IDLE next cycle.
- **Mid-operation changes and reset.** Toggle `op_i` and `data_i` during RUN → result unaffected. Then assert `rst_i` at RUN cycle 8 → next cycle IDLE, `out_valid_o`=0, `data_o`=0, and no output is ever produced for that state.
- **Parallel lookups.** Repeat the ascending-bytes test with NUM_SBOX=4 and 16 → identical `data_o`, latency 5 and 2 cycles respectively. Back-to-back traffic with `out_ready_i`=1 has period G+2.
